// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 sequencer: steps the shared ALU/memory datapath through FETCH..WB.
// Optional retired-instruction counter enabled by defining PERF_COUNT_EN.
module multicycle_control (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [10:0] opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pcwrite,
  output logic        irwrite,
  output logic        iord,
  output logic        pc_inc,
  output logic        reg2loc,
  output logic        alusrc,
  output logic        mem2reg,
  output logic        regwrite,
  output logic        memread,
  output logic        memwrite,
  output logic [3:0]  aluop,
  output logic [2:0]  signop,
  output logic [2:0]  state,
  output logic        instr_done,
`ifdef PERF_COUNT_EN
  output logic        illegal,
  output logic [31:0] retired
`else
  output logic        illegal
`endif
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    I_LDUR, I_STUR, I_ADD, I_ADDI, I_SUB, I_SUBI, I_AND, I_ORR,
    I_CBZ, I_B, I_MOVZ, I_LSL, I_LSR, I_ILL
  } instr_t;

  // casez order gives the single-cycle decode priority
  function automatic instr_t classify(input logic [10:0] op);
    instr_t c;
    casez (op)
      11'b11111000010: c = I_LDUR;
      11'b11111000000: c = I_STUR;
      11'b10001011000: c = I_ADD;
      11'b1001000100?: c = I_ADDI;
      11'b11001011000: c = I_SUB;
      11'b1101000100?: c = I_SUBI;
      11'b10001010000: c = I_AND;
      11'b10101010000: c = I_ORR;
      11'b10110100???: c = I_CBZ;
      11'b000101?????: c = I_B;
      11'b110100101??: c = I_MOVZ;
      11'b11010011011: c = I_LSL;
      11'b11010011010: c = I_LSR;
      default:         c = I_ILL;
    endcase
    return c;
  endfunction

  state_t      state_reg, state_next;
  logic [10:0] op_reg;
  instr_t      in_cls, cls;
  logic [3:0]  sel_aluop;
  logic [2:0]  sel_signop;
  logic        sel_alusrc, sel_reg2loc;

  assign in_cls = classify(opcode);
  assign cls    = classify(op_reg);
  assign state  = Reset ? 3'd0 : state_reg;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_reg <= FETCH;
      op_reg    <= 11'd0;
    end else begin
      state_reg <= state_next;
      if (state_reg == DECODE) op_reg <= opcode;
    end
  end

  // ALU/extend selects are held from EXEC through WB so the ALU result stays valid
  always_comb begin
    sel_aluop   = 4'b0000;
    sel_signop  = 3'b000;
    sel_alusrc  = 1'b0;
    sel_reg2loc = (cls == I_STUR) || (cls == I_CBZ);
    case (cls)
      I_LDUR, I_STUR: begin sel_aluop = 4'b0010; sel_alusrc = 1'b1; sel_signop = 3'b001; end
      I_ADD:          sel_aluop = 4'b0010;
      I_ADDI:         begin sel_aluop = 4'b0010; sel_alusrc = 1'b1; end
      I_SUB:          sel_aluop = 4'b0110;
      I_SUBI:         begin sel_aluop = 4'b0110; sel_alusrc = 1'b1; end
      I_AND:          sel_aluop = 4'b0000;
      I_ORR:          sel_aluop = 4'b0001;
      I_CBZ:          begin sel_aluop = 4'b0111; sel_signop = 3'b011; end
      I_B:            sel_signop = 3'b010;
      I_MOVZ:         begin sel_aluop = 4'b0111; sel_alusrc = 1'b1; sel_signop = 3'b101; end
      I_LSL:          begin sel_aluop = 4'b0011; sel_alusrc = 1'b1; sel_signop = 3'b100; end
      I_LSR:          begin sel_aluop = 4'b0100; sel_alusrc = 1'b1; sel_signop = 3'b100; end
      default:        sel_aluop = 4'b0000;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    pcwrite    = 1'b0;
    irwrite    = 1'b0;
    iord       = 1'b0;
    pc_inc     = 1'b0;
    reg2loc    = 1'b0;
    alusrc     = 1'b0;
    mem2reg    = 1'b0;
    regwrite   = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    aluop      = 4'b0000;
    signop     = 3'b000;
    instr_done = 1'b0;
    illegal    = 1'b0;
    if (!Reset) begin
      case (state_reg)
        FETCH: begin
          memread = 1'b1;
          if (mem_ready) begin
            irwrite    = 1'b1;
            pcwrite    = 1'b1;
            pc_inc     = 1'b1;
            state_next = DECODE;
          end
        end
        DECODE: begin
          reg2loc = (in_cls == I_STUR) || (in_cls == I_CBZ);
          if (in_cls == I_ILL) begin
            illegal    = 1'b1;
            instr_done = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = EXEC;
          end
        end
        EXEC: begin
          aluop   = sel_aluop;
          alusrc  = sel_alusrc;
          signop  = sel_signop;
          reg2loc = sel_reg2loc;
          case (cls)
            I_LDUR, I_STUR: state_next = MEM;
            I_CBZ: begin pcwrite = zero; instr_done = 1'b1; state_next = FETCH; end
            I_B:   begin pcwrite = 1'b1; instr_done = 1'b1; state_next = FETCH; end
            I_ILL: state_next = FETCH;
            default: state_next = WB;
          endcase
        end
        MEM: begin
          aluop    = sel_aluop;
          alusrc   = sel_alusrc;
          signop   = sel_signop;
          reg2loc  = sel_reg2loc;
          iord     = 1'b1;
          memread  = (cls == I_LDUR);
          memwrite = (cls == I_STUR);
          if (mem_ready) begin
            if (cls == I_STUR) begin
              instr_done = 1'b1;
              state_next = FETCH;
            end else begin
              state_next = WB;
            end
          end
        end
        WB: begin
          aluop      = sel_aluop;
          alusrc     = sel_alusrc;
          signop     = sel_signop;
          reg2loc    = sel_reg2loc;
          regwrite   = 1'b1;
          mem2reg    = (cls == I_LDUR);
          instr_done = 1'b1;
          state_next = FETCH;
        end
        default: state_next = FETCH;
      endcase
    end
  end

`ifdef PERF_COUNT_EN
  logic [31:0] count_reg;

  always_ff @(posedge CLK) begin
    if (Reset)
      count_reg <= 32'd0;
    else if (instr_done && !illegal)
      count_reg <= count_reg + 32'd1;
  end

  assign retired = Reset ? 32'd0 : count_reg;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control; PERF_COUNT_EN adds the counter test.
module tb_multicycle_control;
  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [10:0] opcode = 11'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pcwrite, irwrite, iord, pc_inc, reg2loc, alusrc, mem2reg;
  logic        regwrite, memread, memwrite, instr_done, illegal;
  logic [3:0]  aluop;
  logic [2:0]  signop, state;
`ifdef PERF_COUNT_EN
  logic [31:0] retired;
`endif
  logic [21:0] obs;
  int tests = 0;
  int fails = 0;

  multicycle_control dut (
    .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .irwrite(irwrite), .iord(iord), .pc_inc(pc_inc),
    .reg2loc(reg2loc), .alusrc(alusrc), .mem2reg(mem2reg), .regwrite(regwrite),
    .memread(memread), .memwrite(memwrite), .aluop(aluop), .signop(signop),
    .state(state), .instr_done(instr_done),
`ifdef PERF_COUNT_EN
    .illegal(illegal), .retired(retired)
`else
    .illegal(illegal)
`endif
  );

  always #5 CLK = ~CLK;

  assign obs = {pcwrite, irwrite, iord, pc_inc, reg2loc, alusrc, mem2reg, regwrite,
                memread, memwrite, aluop, signop, state, instr_done, illegal};

  localparam logic [21:0] PCW   = 22'd1 << 21;
  localparam logic [21:0] IRW   = 22'd1 << 20;
  localparam logic [21:0] IORD  = 22'd1 << 19;
  localparam logic [21:0] PCINC = 22'd1 << 18;
  localparam logic [21:0] R2L   = 22'd1 << 17;
  localparam logic [21:0] ASRC  = 22'd1 << 16;
  localparam logic [21:0] M2R   = 22'd1 << 15;
  localparam logic [21:0] RW    = 22'd1 << 14;
  localparam logic [21:0] MRD   = 22'd1 << 13;
  localparam logic [21:0] MWR   = 22'd1 << 12;
  localparam logic [21:0] DONE  = 22'd1 << 1;
  localparam logic [21:0] ILL   = 22'd1;
  localparam logic [21:0] FE    = PCW | IRW | PCINC | MRD;

  function automatic logic [21:0] f(input logic [3:0] a, input logic [2:0] s, input logic [2:0] st);
    return {10'b0, a, s, st, 2'b0};
  endfunction

  task automatic run_instr(input logic [10:0] op, input int n);
    repeat (n) begin
      @(negedge CLK); Reset = 1'b0; opcode = op; mem_ready = 1'b1;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK); Reset = (i < 3); mem_ready = (i < 3); opcode = 11'h458; #1;
      tests++;
      if (obs !== ((i < 3) ? 22'd0 : MRD)) begin
        fails++; $display("FAIL reset cyc%0d got %h want %h", i, obs, (i < 3) ? 22'd0 : MRD);
      end
    end
    $display("[TB] reset sequence checked");
  endtask

  task automatic test_addreg();
    logic [21:0] ev [4];
    ev = '{FE, f(0, 0, 1), f(4'b0010, 0, 2), RW | DONE | f(4'b0010, 0, 4)};
    for (int i = 0; i < 4; i++) begin
      // opcode changes after DECODE must not matter
      @(negedge CLK); mem_ready = 1'b1; opcode = (i < 2) ? 11'h458 : 11'h7C0; #1;
      tests++;
      if (obs !== ev[i]) begin
        fails++; $display("FAIL addreg cyc%0d got %h want %h", i, obs, ev[i]);
      end
    end
    $display("[TB] ADDREG transaction checked");
  endtask

  task automatic test_alu_ops();
    logic [10:0] ops [8];
    logic [21:0] sel [8];
    logic [21:0] want;
    ops = '{11'h488, 11'h658, 11'h688, 11'h450, 11'h550, 11'h694, 11'h69B, 11'h69A};
    sel = '{ASRC | f(4'b0010, 3'b000, 0), f(4'b0110, 3'b000, 0), ASRC | f(4'b0110, 3'b000, 0),
            f(4'b0000, 3'b000, 0), f(4'b0001, 3'b000, 0), ASRC | f(4'b0111, 3'b101, 0),
            ASRC | f(4'b0011, 3'b100, 0), ASRC | f(4'b0100, 3'b100, 0)};
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge CLK); mem_ready = 1'b1; opcode = ops[k]; #1;
        case (i)
          0: want = FE;
          1: want = f(0, 0, 1);
          2: want = sel[k] | f(0, 0, 2);
          default: want = sel[k] | RW | DONE | f(0, 0, 4);
        endcase
        tests++;
        if (obs !== want) begin
          fails++; $display("FAIL aluop op%h cyc%0d got %h want %h", ops[k], i, obs, want);
        end
      end
      $display("[TB] opcode %h transaction checked", ops[k]);
    end
  endtask

  task automatic test_ldur_stall();
    logic [21:0] ev [7];
    logic        rdy [7];
    logic [21:0] mw;
    mw = IORD | MRD | ASRC | f(4'b0010, 3'b001, 3);
    ev = '{FE, f(0, 0, 1), ASRC | f(4'b0010, 3'b001, 2), mw, mw, mw,
           RW | M2R | ASRC | DONE | f(4'b0010, 3'b001, 4)};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      @(negedge CLK); mem_ready = rdy[i]; opcode = 11'h7C2; #1;
      tests++;
      if (obs !== ev[i]) begin
        fails++; $display("FAIL ldur cyc%0d got %h want %h", i, obs, ev[i]);
      end
    end
    $display("[TB] LDUR with MEM stall checked");
  endtask

  task automatic test_branches();
    logic [21:0] ev [9];
    logic        zv [9];
    logic [10:0] opv [9];
    ev  = '{FE, R2L | f(0, 0, 1), R2L | PCW | DONE | f(4'b0111, 3'b011, 2),
            FE, R2L | f(0, 0, 1), R2L | DONE | f(4'b0111, 3'b011, 2),
            FE, f(0, 0, 1), PCW | DONE | f(0, 3'b010, 2)};
    zv  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    opv = '{11'h5A0, 11'h5A0, 11'h5A0, 11'h5A0, 11'h5A0, 11'h5A0, 11'h0A0, 11'h0A0, 11'h0A0};
    for (int i = 0; i < 9; i++) begin
      @(negedge CLK); mem_ready = 1'b1; zero = zv[i]; opcode = opv[i]; #1;
      tests++;
      if (obs !== ev[i]) begin
        fails++; $display("FAIL branch cyc%0d got %h want %h", i, obs, ev[i]);
      end
    end
    zero = 1'b0;
    $display("[TB] CBZ taken, CBZ not taken, B checked");
  endtask

  task automatic test_stur_reset();
    logic [21:0] ev [6];
    logic        rdy [6];
    logic        rst [6];
    ev  = '{FE, R2L | f(0, 0, 1), R2L | ASRC | f(4'b0010, 3'b001, 2),
            R2L | IORD | MWR | ASRC | f(4'b0010, 3'b001, 3), 22'd0, MRD};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    rst = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK); mem_ready = rdy[i]; Reset = rst[i]; opcode = 11'h7C0; #1;
      tests++;
      if (obs !== ev[i]) begin
        fails++; $display("FAIL stur_reset cyc%0d got %h want %h", i, obs, ev[i]);
      end
    end
    $display("[TB] STUR aborted by reset in MEM wait checked");
  endtask

  task automatic test_illegal();
    logic [21:0] ev [3];
    ev = '{FE, ILL | DONE | f(0, 0, 1), MRD};
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); mem_ready = (i < 2); opcode = 11'h000; #1;
      tests++;
      if (obs !== ev[i]) begin
        fails++; $display("FAIL illegal cyc%0d got %h want %h", i, obs, ev[i]);
      end
    end
    $display("[TB] illegal opcode checked");
  endtask

`ifdef PERF_COUNT_EN
  task automatic test_perf_count();
    @(negedge CLK); Reset = 1'b1;
    for (int k = 0; k < 10; k++) run_instr(11'h488, 4);
    run_instr(11'h000, 2);
    @(negedge CLK); mem_ready = 1'b0; #1;
    tests++;
    if (retired !== 32'd10) begin
      fails++; $display("FAIL retired_count got %0d want 10", retired);
    end
    force dut.count_reg = 32'hFFFF_FFFF;
    #1;
    release dut.count_reg;
    run_instr(11'h488, 4);
    @(negedge CLK); mem_ready = 1'b0; #1;
    tests++;
    if (retired !== 32'd0) begin
      fails++; $display("FAIL retired_wrap got %h want 00000000", retired);
    end
    $display("[TB] retired counter checked");
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    @(negedge CLK); mem_ready = 1'b0;
    test_addreg();
    test_alu_ops();
    test_ldur_stall();
    test_branches();
    test_stur_reset();
    test_illegal();
`ifdef PERF_COUNT_EN
    test_perf_count();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
